awb_gain: RTL and testbench
===========================

AWB_GAIN -- requirements
Module: awb_gain

Interface
REQ-001 Parameters SHALL be: DW, 16, pixel width; H, 1280, active pixels per line; V, 720, lines per frame; HW, 11, h counter width; VW, 10, v counter width; GW, 12, gain width, unsigned Q4.8 (0x100 = 1.0); SW, DW+HW+VW, statistic sum width.
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 awb_en  input  1  stage enable.
REQ-005 bayer_pat  input  2  CFA phase of pixel (0,0): 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR.
REQ-006 r_gain, gr_gain, gb_gain, b_gain  input  GW each  per-channel gains.
REQ-007 pixel_data_in  input  DW  raw pixel from the upstream anti-aliasing filter stage, raster order.
REQ-008 pixel_data_in_vld  input  1  pixel qualifier; gaps allowed anywhere.
REQ-009 pixel_data_out  output  DW  gained pixel.
REQ-010 pixel_data_out_vld  output  1  output qualifier.
REQ-011 stat_r_sum, stat_g_sum, stat_b_sum  output  SW each  last completed frame channel sums.
REQ-012 stat_vld  output  1  one-cycle pulse; stat sums updated this cycle.
REQ-013 awb_done  output  1  one-cycle pulse on the last output pixel of a frame.

Function
REQ-014 h_cnt (0..H-1) and v_cnt (0..V-1) SHALL advance only on accepted pixels (awb_en=1 and pixel_data_in_vld=1); h wraps H-1->0 and increments v; v wraps V-1->0.
REQ-015 FSM states: IDLE, RUN. IDLE->RUN when awb_en=1; RUN->IDLE only when awb_en=0 and h_cnt=v_cnt=0 (frame boundary); awb_en deasserted mid-frame SHALL be ignored until the current frame completes.
REQ-016 In IDLE pixels SHALL pass through with gain 1.0 and the same 2-cycle latency; counters held at 0; no accumulation, no stat_vld/awb_done.
REQ-017 Gains and bayer_pat SHALL be captured into shadow registers on the accepted pixel with h_cnt=v_cnt=0; mid-frame changes take effect only at the next frame.
REQ-018 Channel select: phase = {v_cnt[0],h_cnt[0]} XOR-mapped via shadow bayer_pat; Gr = green on an R line, Gb = green on a B line.
REQ-019 Stage 1 SHALL register pixel, selected gain, channel tag, last-pixel tag (h=H-1,v=V-1) and valid.
REQ-020 Stage 2 SHALL compute (pixel*gain + 128) >> 8, saturate to 2^DW-1, and register it; pixel_data_out_vld = input valid delayed exactly 2 cycles.
REQ-021 pixel_data_out SHALL hold its last value when pixel_data_out_vld=0.
REQ-022 Accumulators (SW bits) SHALL add each valid stage-2 output to the R, G (Gr and Gb), or B sum; no overflow possible at max parameters.
REQ-023 On the stage-2 output with last tag: stat sums load accumulator totals including that pixel, stat_vld and awb_done pulse high 1 cycle coincident with that output, accumulators clear to 0.
REQ-024 A first pixel of the next frame arriving back-to-back with the last pixel SHALL be accumulated into the fresh frame, not lost or double-counted.
REQ-025 Stat outputs SHALL hold until the next frame completes.

Reset
REQ-026 On rst=1 at a clock edge: FSM=IDLE, counters, pipeline valids, accumulators, shadow gains (to 0x100), shadow bayer_pat (to 0), pixel_data_out, stat sums all 0/default; stat_vld, awb_done, pixel_data_out_vld = 0 the following cycle.
REQ-027 Reset mid-frame SHALL discard in-flight pixels and partial sums; the next accepted pixel is treated as (0,0).

Verification (bench uses H=4, V=2)
REQ-028 awb_en=1, RGGB, r_gain=0x200, pixel (0,0)=100 -> pixel_data_out=200 with vld exactly 2 cycles after input.
REQ-029 Saturation/rounding: pixel 0xF000 gain 0x200 -> 0xFFFF; pixel 3 gain 0x080 -> 2.
REQ-030 Full frame, all pixels 10, all gains 0x100, RGGB -> stat_r=20, stat_g=40, stat_b=20, stat_vld and awb_done high 1 cycle with the 8th output.
REQ-031 Change b_gain 0x100->0x300 after pixel (1,0) -> current frame B outputs unscaled; next frame B outputs x3.
REQ-032 Random vld gaps and back-to-back frames -> outputs/sums match reference model; no pixel lost across frame boundary.
REQ-033 rst pulsed after 5 pixels -> outputs idle next cycle, no stat_vld; subsequent full frame yields correct sums from zero.

Source files
------------

// File: rtl/awb_gain.sv
// Auto-white-balance gain stage for raw Bayer pixels.
// Applies per-CFA-channel Q4.8 gains and accumulates per-frame channel sums.
module awb_gain #(
  parameter int DW = 16,
  parameter int H  = 1280,
  parameter int V  = 720,
  parameter int HW = 11,
  parameter int VW = 10,
  parameter int GW = 12,
  parameter int SW = DW + HW + VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          awb_en,
  input  logic [1:0]    bayer_pat,
  input  logic [GW-1:0] r_gain,
  input  logic [GW-1:0] gr_gain,
  input  logic [GW-1:0] gb_gain,
  input  logic [GW-1:0] b_gain,
  input  logic [DW-1:0] pixel_data_in,
  input  logic          pixel_data_in_vld,
  output logic [DW-1:0] pixel_data_out,
  output logic          pixel_data_out_vld,
  output logic [SW-1:0] stat_r_sum,
  output logic [SW-1:0] stat_g_sum,
  output logic [SW-1:0] stat_b_sum,
  output logic          stat_vld,
  output logic          awb_done
);

  localparam int PW = DW + GW;
  localparam logic [GW-1:0] UNITY = GW'(256);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_run;
  logic          w_acc;
  logic          w_sof;
  logic          w_last;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;

  logic [GW-1:0] r_sh_r;
  logic [GW-1:0] r_sh_gr;
  logic [GW-1:0] r_sh_gb;
  logic [GW-1:0] r_sh_b;
  logic [1:0]    r_sh_pat;
  logic [1:0]    w_pat;
  logic [1:0]    w_ch;
  logic [GW-1:0] w_gsel;

  logic [DW-1:0] r_s1_pix;
  logic [GW-1:0] r_s1_gain;
  logic [1:0]    r_s1_ch;
  logic          r_s1_last;
  logic          r_s1_vld;
  logic          r_s1_run;

  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_rnd;
  logic [DW-1:0] w_sat;
  logic [SW-1:0] w_add;
  logic          w_s2_acc;
  logic [SW-1:0] w_r_nxt;
  logic [SW-1:0] w_g_nxt;
  logic [SW-1:0] w_b_nxt;

  logic [DW-1:0] r_out;
  logic          r_out_vld;
  logic [SW-1:0] r_acc_r;
  logic [SW-1:0] r_acc_g;
  logic [SW-1:0] r_acc_b;
  logic [SW-1:0] r_st_r;
  logic [SW-1:0] r_st_g;
  logic [SW-1:0] r_st_b;
  logic          r_st_vld;

  assign w_sof  = (r_h == '0) && (r_v == '0);
  assign w_last = (r_h == HW'(H - 1)) && (r_v == VW'(V - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state: leave RUN only at a frame boundary
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (awb_en) w_next = S_RUN;
      S_RUN:   if (!awb_en && w_sof) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: a pixel is gained if enabled now or mid-frame
  always_comb begin
    w_run = awb_en | ((r_state == S_RUN) & ~w_sof);
    w_acc = w_run & pixel_data_in_vld;
  end

  // Raster position, advancing on accepted pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_acc) begin
      if (r_h == HW'(H - 1)) begin
        r_h <= '0;
        r_v <= (r_v == VW'(V - 1)) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  // Shadow gains and pattern, frozen at the first pixel of a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_r   <= UNITY;
      r_sh_gr  <= UNITY;
      r_sh_gb  <= UNITY;
      r_sh_b   <= UNITY;
      r_sh_pat <= 2'd0;
    end else if (w_acc && w_sof) begin
      r_sh_r   <= r_gain;
      r_sh_gr  <= gr_gain;
      r_sh_gb  <= gb_gain;
      r_sh_b   <= b_gain;
      r_sh_pat <= bayer_pat;
    end
  end

  // Channel select; the (0,0) pixel uses the values being captured
  always_comb begin
    w_pat = w_sof ? bayer_pat : r_sh_pat;
    w_ch  = {r_v[0], r_h[0]} ^ w_pat;
    w_gsel = UNITY;
    unique case (w_ch)
      2'd0: w_gsel = w_sof ? r_gain  : r_sh_r;
      2'd1: w_gsel = w_sof ? gr_gain : r_sh_gr;
      2'd2: w_gsel = w_sof ? gb_gain : r_sh_gb;
      2'd3: w_gsel = w_sof ? b_gain  : r_sh_b;
      default: w_gsel = UNITY;
    endcase
  end

  // Stage 1: register pixel, gain, channel and tags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_pix  <= '0;
      r_s1_gain <= UNITY;
      r_s1_ch   <= 2'd0;
      r_s1_last <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s1_run  <= 1'b0;
    end else begin
      r_s1_pix  <= pixel_data_in;
      r_s1_gain <= w_run ? w_gsel : UNITY;
      r_s1_ch   <= w_ch;
      r_s1_last <= w_acc & w_last;
      r_s1_vld  <= pixel_data_in_vld;
      r_s1_run  <= w_acc;
    end
  end

  // Multiply, round, saturate and form next channel sums
  always_comb begin
    w_prod   = PW'(r_s1_pix) * PW'(r_s1_gain);
    w_rnd    = (w_prod + PW'(128)) >> 8;
    w_sat    = (|w_rnd[PW-1:DW]) ? '1 : w_rnd[DW-1:0];
    w_add    = SW'(w_sat);
    w_s2_acc = r_s1_vld & r_s1_run;
    w_r_nxt  = r_acc_r;
    w_g_nxt  = r_acc_g;
    w_b_nxt  = r_acc_b;
    if (w_s2_acc) begin
      unique case (r_s1_ch)
        2'd0:    w_r_nxt = r_acc_r + w_add;
        2'd3:    w_b_nxt = r_acc_b + w_add;
        default: w_g_nxt = r_acc_g + w_add;
      endcase
    end
  end

  // Stage 2: output register, holds value between valid pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= r_s1_vld;
      if (r_s1_vld) r_out <= w_sat;
    end
  end

  // Accumulate; on the last pixel publish totals and restart from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_r  <= '0;
      r_acc_g  <= '0;
      r_acc_b  <= '0;
      r_st_r   <= '0;
      r_st_g   <= '0;
      r_st_b   <= '0;
      r_st_vld <= 1'b0;
    end else begin
      r_st_vld <= w_s2_acc & r_s1_last;
      if (w_s2_acc && r_s1_last) begin
        r_st_r  <= w_r_nxt;
        r_st_g  <= w_g_nxt;
        r_st_b  <= w_b_nxt;
        r_acc_r <= '0;
        r_acc_g <= '0;
        r_acc_b <= '0;
      end else begin
        r_acc_r <= w_r_nxt;
        r_acc_g <= w_g_nxt;
        r_acc_b <= w_b_nxt;
      end
    end
  end

  assign pixel_data_out     = r_out;
  assign pixel_data_out_vld = r_out_vld;
  assign stat_r_sum         = r_st_r;
  assign stat_g_sum         = r_st_g;
  assign stat_b_sum         = r_st_b;
  assign stat_vld           = r_st_vld;
  assign awb_done           = r_st_vld;

endmodule

// File: tb/tb_awb_gain.sv
// Self-checking bench for awb_gain on a 4x2 frame.
// Reference model works per frame pixel index with a CFA layout table.
module tb_awb_gain;
  localparam int DW = 16;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int HW = 2;
  localparam int VW = 1;
  localparam int GW = 12;
  localparam int SW = DW + HW + VW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          awb_en = 1'b0;
  logic [1:0]    bayer_pat = 2'd0;
  logic [GW-1:0] r_gain = 12'h100;
  logic [GW-1:0] gr_gain = 12'h100;
  logic [GW-1:0] gb_gain = 12'h100;
  logic [GW-1:0] b_gain = 12'h100;
  logic [DW-1:0] pixel_data_in = '0;
  logic          pixel_data_in_vld = 1'b0;
  logic [DW-1:0] pixel_data_out;
  logic          pixel_data_out_vld;
  logic [SW-1:0] stat_r_sum;
  logic [SW-1:0] stat_g_sum;
  logic [SW-1:0] stat_b_sum;
  logic          stat_vld;
  logic          awb_done;

  always #5 clk = ~clk;

  awb_gain #(
    .DW(DW), .H(H), .V(V), .HW(HW), .VW(VW), .GW(GW), .SW(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .awb_en(awb_en),
    .bayer_pat(bayer_pat),
    .r_gain(r_gain),
    .gr_gain(gr_gain),
    .gb_gain(gb_gain),
    .b_gain(b_gain),
    .pixel_data_in(pixel_data_in),
    .pixel_data_in_vld(pixel_data_in_vld),
    .pixel_data_out(pixel_data_out),
    .pixel_data_out_vld(pixel_data_out_vld),
    .stat_r_sum(stat_r_sum),
    .stat_g_sum(stat_g_sum),
    .stat_b_sum(stat_b_sum),
    .stat_vld(stat_vld),
    .awb_done(awb_done)
  );

  typedef struct {
    int     due;
    longint out;
    bit     last;
    longint sr;
    longint sg;
    longint sb;
  } exp_t;

  exp_t   q[$];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  longint last_out = 0;
  longint es_r = 0, es_g = 0, es_b = 0;
  int     m_idx = 0;
  int     sh_g[4] = '{256, 256, 256, 256};
  int     sh_pat = 0;
  longint m_r = 0, m_g = 0, m_b = 0;
  string  lay[4] = '{"RgGB", "gRBG", "GBRg", "BGgR"};

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int chan(int pat, int row, int col);
    string s;
    s = lay[pat];
    case (s[row * 2 + col])
      "R":     return 0;
      "g":     return 1;
      "G":     return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model(logic [DW-1:0] p);
    exp_t   e;
    int     k;
    longint o;
    e.last = 0; e.sr = 0; e.sg = 0; e.sb = 0;
    if (awb_en || m_idx != 0) begin
      if (m_idx == 0) begin
        sh_g   = '{int'(r_gain), int'(gr_gain), int'(gb_gain), int'(b_gain)};
        sh_pat = int'(bayer_pat);
      end
      k = chan(sh_pat, (m_idx / H) % 2, (m_idx % H) % 2);
      o = (longint'(p) * sh_g[k] + 128) / 256;
      if (o > 65535) o = 65535;
      if (k == 0) m_r += o;
      else if (k == 3) m_b += o;
      else m_g += o;
      if (m_idx == H * V - 1) begin
        e.last = 1; e.sr = m_r; e.sg = m_g; e.sb = m_b;
        m_r = 0; m_g = 0; m_b = 0;
      end
      m_idx = (m_idx + 1) % (H * V);
    end else begin
      o = longint'(p);
    end
    e.due = cyc + 2;
    e.out = o;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("out_vld", 64'(pixel_data_out_vld), 64'd1);
      chk("out_data", 64'(pixel_data_out), 64'(e.out));
      chk("stat_vld", 64'(stat_vld), 64'(e.last));
      chk("awb_done", 64'(awb_done), 64'(e.last));
      last_out = e.out;
      if (e.last) begin
        es_r = e.sr; es_g = e.sg; es_b = e.sb;
      end
    end else begin
      chk("out_vld_idle", 64'(pixel_data_out_vld), 64'd0);
      chk("out_hold", 64'(pixel_data_out), 64'(last_out));
      chk("stat_vld_idle", 64'(stat_vld), 64'd0);
      chk("awb_done_idle", 64'(awb_done), 64'd0);
    end
    chk("stat_r", 64'(stat_r_sum), 64'(es_r));
    chk("stat_g", 64'(stat_g_sum), 64'(es_g));
    chk("stat_b", 64'(stat_b_sum), 64'(es_b));
  endtask

  task automatic step(bit v, logic [DW-1:0] p);
    pixel_data_in     = p;
    pixel_data_in_vld = v;
    if (v) model(p);
    @(posedge clk);
    cyc++;
    #1;
    check();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    pixel_data_in_vld = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    q.delete();
    m_idx = 0; m_r = 0; m_g = 0; m_b = 0;
    sh_g = '{256, 256, 256, 256};
    sh_pat = 0;
    last_out = 0; es_r = 0; es_g = 0; es_b = 0;
    check();
  endtask

  task automatic gains(int r, int gr, int gb, int b);
    r_gain = GW'(r); gr_gain = GW'(gr); gb_gain = GW'(gb); b_gain = GW'(b);
  endtask

  initial begin
    #1;
    do_rst();

    awb_en = 1'b1; bayer_pat = 2'd0;
    gains(12'h200, 12'h100, 12'h100, 12'h100);
    step(1, 16'd100);
    step(0, 16'd0);
    chk("t1_vld", 64'(pixel_data_out_vld), 64'd1);
    chk("t1_out", 64'(pixel_data_out), 64'd200);
    for (int i = 1; i < H * V; i++) step(1, DW'($urandom));
    step(0, '0); step(0, '0);

    gains(12'h200, 12'h080, 12'h100, 12'h100);
    step(1, 16'hF000);
    step(1, 16'd3);
    chk("sat_out", 64'(pixel_data_out), 64'hFFFF);
    step(0, '0);
    chk("rnd_out", 64'(pixel_data_out), 64'd2);
    for (int i = 2; i < H * V; i++) step(1, DW'($urandom));
    step(0, '0); step(0, '0);

    gains(12'h100, 12'h100, 12'h100, 12'h100);
    for (int i = 0; i < H * V; i++) step(1, 16'd10);
    step(0, '0);
    chk("t3_stat_vld", 64'(stat_vld), 64'd1);
    chk("t3_done", 64'(awb_done), 64'd1);
    step(0, '0);
    chk("t3_stat_vld_off", 64'(stat_vld), 64'd0);
    chk("t3_r", 64'(stat_r_sum), 64'd20);
    chk("t3_g", 64'(stat_g_sum), 64'd40);
    chk("t3_b", 64'(stat_b_sum), 64'd20);

    for (int i = 0; i < H * V; i++) begin
      step(1, 16'd10);
      if (i == 4) b_gain = 12'h300;
    end
    for (int i = 0; i < H * V; i++) step(1, 16'd10);
    step(0, '0); step(0, '0);
    chk("t4_r", 64'(stat_r_sum), 64'd20);
    chk("t4_g", 64'(stat_g_sum), 64'd40);
    chk("t4_b", 64'(stat_b_sum), 64'd60);

    awb_en = 1'b0;
    for (int i = 0; i < 3; i++) step(1, DW'($urandom));
    step(0, '0); step(0, '0);

    awb_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0)
        gains($urandom_range(0, 4095), $urandom_range(0, 4095),
              $urandom_range(0, 4095), $urandom_range(0, 4095));
      if ($urandom_range(0, 7) == 0) bayer_pat = 2'($urandom_range(0, 3));
      awb_en = ($urandom_range(0, 9) != 0);
      step($urandom_range(0, 3) != 0, DW'($urandom));
    end
    awb_en = 1'b1;
    for (int i = 0; i < 2 * H * V; i++) step(1, DW'($urandom));
    step(0, '0); step(0, '0);

    gains(12'h100, 12'h100, 12'h100, 12'h100);
    bayer_pat = 2'd0;
    for (int i = 0; i < 5; i++) step(1, 16'd77);
    do_rst();
    chk("rst_mid_vld", 64'(pixel_data_out_vld), 64'd0);
    chk("rst_mid_stat", 64'(stat_vld), 64'd0);
    step(0, '0);
    chk("rst_mid_vld2", 64'(pixel_data_out_vld), 64'd0);
    for (int i = 0; i < H * V; i++) step(1, 16'd10);
    step(0, '0); step(0, '0);
    chk("t7_r", 64'(stat_r_sum), 64'd20);
    chk("t7_g", 64'(stat_g_sum), 64'd40);
    chk("t7_b", 64'(stat_b_sum), 64'd20);

    for (int i = 0; i < 3; i++) step(0, '0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
